// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-latency lookup on PC_F, one-cycle update from execute.
// No backpressure: one lookup and at most one update every cycle.
package bp_pkg;
  typedef enum logic [1:0] {
    STRONGLY_UNTAKEN = 2'b00,
    WEAKLY_UNTAKEN   = 2'b01,
    WEAKLY_TAKEN     = 2'b10,
    STRONGLY_TAKEN   = 2'b11
  } ctr_state_t;

  localparam logic PREDICT_TAKEN     = 1'b1;
  localparam logic PREDICT_NOT_TAKEN = 1'b0;
  localparam logic BRANCH_TAKEN      = 1'b1;
  localparam logic BRANCH_NOT_TAKEN  = 1'b0;
endpackage

module branch_predictor #(
  parameter int ENTRIES = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] PC_F,
  output logic        Predict_Taken,
  output logic [31:0] Predict_Target,
  input  logic        Update_En,
  input  logic        Is_Jump_E,
  input  logic [31:0] PC_E,
  input  logic        Branch_Taken_E,
  input  logic [31:0] Branch_Target_E
);
  import bp_pkg::*;

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  ctr_state_t       state_q  [ENTRIES];

  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;
  logic             f_hit, e_hit, e_taken;
  logic [31:0]      seq_pc;
  logic             unused_pc_lsbs;

  logic       wr_state, wr_alloc, wr_target;
  ctr_state_t next_state;

  function automatic ctr_state_t sat_inc(input ctr_state_t s);
    case (s)
      STRONGLY_UNTAKEN: sat_inc = WEAKLY_UNTAKEN;
      WEAKLY_UNTAKEN:   sat_inc = WEAKLY_TAKEN;
      default:          sat_inc = STRONGLY_TAKEN;
    endcase
  endfunction

  function automatic ctr_state_t sat_dec(input ctr_state_t s);
    case (s)
      STRONGLY_TAKEN: sat_dec = WEAKLY_TAKEN;
      WEAKLY_TAKEN:   sat_dec = WEAKLY_UNTAKEN;
      default:        sat_dec = STRONGLY_UNTAKEN;
    endcase
  endfunction

  assign f_idx = PC_F[IDX_W+1:2];
  assign f_tag = PC_F[31:IDX_W+2];
  assign e_idx = PC_E[IDX_W+1:2];
  assign e_tag = PC_E[31:IDX_W+2];
  assign unused_pc_lsbs = ^{PC_F[1:0], PC_E[1:0]};

  // Lookup reads registered contents only, so a same-cycle update is not bypassed.
  assign f_hit  = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign seq_pc = PC_F + 32'd4;

  always_comb begin
    Predict_Taken  = PREDICT_NOT_TAKEN;
    Predict_Target = seq_pc;
    if (!RST && f_hit && state_q[f_idx][1]) begin
      Predict_Taken  = PREDICT_TAKEN;
      Predict_Target = target_q[f_idx];
    end
  end

  assign e_hit   = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
  assign e_taken = Is_Jump_E || (Branch_Taken_E == BRANCH_TAKEN);

  always_comb begin
    wr_state   = 1'b0;
    wr_alloc   = 1'b0;
    wr_target  = 1'b0;
    next_state = state_q[e_idx];
    if (Update_En) begin
      if (e_hit) begin
        wr_state = 1'b1;
        if (Is_Jump_E) begin
          next_state = STRONGLY_TAKEN;
          wr_target  = 1'b1;
        end else if (Branch_Taken_E == BRANCH_TAKEN) begin
          next_state = sat_inc(state_q[e_idx]);
          wr_target  = 1'b1;
        end else begin
          next_state = sat_dec(state_q[e_idx]);
        end
      end else if (e_taken) begin
        // Not-taken misses are never allocated; they would only pollute the table.
        wr_state   = 1'b1;
        wr_alloc   = 1'b1;
        wr_target  = 1'b1;
        next_state = Is_Jump_E ? STRONGLY_TAKEN : WEAKLY_TAKEN;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        state_q[i] <= WEAKLY_UNTAKEN;
      end
    end else if (wr_state) begin
      state_q[e_idx] <= next_state;
      if (wr_alloc) valid_q[e_idx] <= 1'b1;
    end
  end

  // Tag and target are don't-care while invalid, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (!RST && wr_alloc)  tag_q[e_idx]    <= e_tag;
    if (!RST && wr_target) target_q[e_idx] <= Branch_Target_E;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Fetch-stage dynamic branch predictor for the RV32i pipeline. It holds a direct-mapped branch target buffer (BTB) in which every entry carries a 2-bit saturating counter.
- Lookup: combinational on the fetch PC. It supplies the predicted direction and next-fetch target to the PC-select logic.
- Update: synchronous, driven by the resolved outcome of each branch or jump in the execute stage.
- Counter states use STRONGLY_UNTAKEN/WEAKLY_UNTAKEN/WEAKLY_TAKEN/STRONGLY_TAKEN. The direction output uses PREDICT_TAKEN/PREDICT_NOT_TAKEN from the shared definitions package.

Parameters:
ENTRIES, 64, number of BTB entries; must be a power of two, from 4 to 256.
IDX_W, log2(ENTRIES), derived index width; not overridable.
TAG_W, 30-IDX_W, derived tag width; not overridable.

Ports:
CLK  input  1  system clock; all state updates on rising edge.
RST  input  1  reset: one clock, synchronous, active-high.
PC_F  input  32  fetch-stage PC being looked up.
Predict_Taken  output  1  PREDICT_TAKEN when the BTB hits and counter[1]=1.
Predict_Target  output  32  stored target when Predict_Taken, else PC_F+4.
Update_En  input  1  execute stage is resolving a B-type, JAL or JALR this cycle.
Is_Jump_E  input  1  resolved instruction is JAL/JALR (unconditional).
PC_E  input  32  PC of the resolved instruction.
Branch_Taken_E  input  1  BRANCH_TAKEN/BRANCH_NOT_TAKEN actual outcome.
Branch_Target_E  input  32  actual computed target address.

Behaviour:
- Addressing: index = PC[IDX_W+1:2]; tag = PC[31:IDX_W+2]. PC[1:0] is ignored for both lookup and update.
- Entry fields: Valid (1), Tag (TAG_W), Target (32), State (2).
- Lookup (combinational, zero latency):
  - hit = Valid[idx] && Tag[idx]==tag(PC_F).
  - Predict_Taken = hit && State[idx][1].
  - Predict_Target = Target[idx] if Predict_Taken, else PC_F+4. The +4 wraps modulo 2^32, so 0xFFFFFFFC gives 0x00000000.
- Update at the rising edge when Update_En=1 and RST=0, at idx/tag from PC_E:
  - Hit, Is_Jump_E=1: State=STRONGLY_TAKEN; Target=Branch_Target_E.
  - Hit, conditional, taken: State saturating increment (STRONGLY_TAKEN stays); Target=Branch_Target_E.
  - Hit, conditional, not taken: State saturating decrement (STRONGLY_UNTAKEN stays); Target unchanged.
  - Miss (invalid or tag mismatch), taken or jump: allocate/replace. Valid=1, Tag=tag(PC_E), Target=Branch_Target_E. State=STRONGLY_TAKEN for a jump, else WEAKLY_TAKEN.
  - Miss, not taken: no change (no allocation of not-taken branches).
  - Is_Jump_E=1 implies taken, regardless of Branch_Taken_E.
- Simultaneous lookup and update of the same index: the lookup sees pre-update contents (no write-to-read bypass). The new state is visible from the next cycle.
- Only one update per cycle; no other entries are touched.
- Reset:
  - RST high at a rising edge clears all Valid bits and sets every State to WEAKLY_UNTAKEN. Tag/Target contents are don't-care.
  - RST has priority over a concurrent Update_En; the update is dropped.
  - While RST=1: Predict_Taken=PREDICT_NOT_TAKEN and Predict_Target=PC_F+4, forced combinationally.
  - After reset, every lookup misses until allocation.
- Misprediction detection and flush are outside this block. The block only learns from updates.
- Storage: registers, because the whole table must be reset in one cycle. No RAM inference required.

Test Plan:
- Reset, then PC_F=0x00000100 -> Predict_Taken=0, Predict_Target=0x00000104. Repeat for all 64 indices; all miss.
- Update_En, PC_E=0x100, taken, target 0x80 -> the same cycle still predicts not-taken. Next cycle PC_F=0x100 gives Predict_Taken=1, Target=0x80, State=WEAKLY_TAKEN.
- Counter saturation on the same entry:
  - Two taken updates -> STRONGLY_TAKEN; a third taken update leaves it at STRONGLY_TAKEN.
  - Then one not-taken -> WEAKLY_TAKEN, still predicts taken.
  - Second not-taken -> WEAKLY_UNTAKEN, predicts 0 with target 0x104.
  - Two more not-taken -> STRONGLY_UNTAKEN and stays there.
- Alias (ENTRIES=64): entry at 0x100, taken update at PC_E=0x200 (same index, different tag) -> replaced. PC_F=0x100 now misses; PC_F=0x200 hits.
  - Also: a not-taken update at an unallocated PC_E=0x300 -> no allocation; a lookup at 0x300 misses.
- JAL at PC_E=0x40, Is_Jump_E=1, Branch_Taken_E=0, target 0x1000 -> allocated STRONGLY_TAKEN; a lookup predicts 0x1000.
  - PC_F=0xFFFFFFFC on a miss -> Predict_Target=0x00000000.
- RST=1 and Update_En=1 in the same cycle on a populated table -> all entries invalid, the update dropped; outputs forced to not-taken during RST.
